// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V hazard unit: forwarding mux encodings and
// the default register-address width.
package riscv_pkg;

  localparam int REG_AW_DEF = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/riscv_mdu_scoreboard.sv
// Single-entry scoreboard tracking the destination of an in-flight MDU op
// with a fixed-latency down-counter; flags issues that arrive while occupied.
module riscv_mdu_scoreboard import riscv_pkg::*; #(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [REG_AW-1:0] rd_in,
  output logic              busy,
  output logic [REG_AW-1:0] rd,
  output logic              wb,
  output logic              err
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

  logic [CNT_W-1:0] cnt;
  logic             complete;
  logic             accept;

  assign complete = busy & (cnt == '0);
  // A new op may take the slot in the very cycle the old result retires.
  assign accept   = start & (~busy | complete);
  assign wb       = complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rd   <= '0;
      err  <= 1'b0;
    end else begin
      if (accept) begin
        busy <= 1'b1;
        rd   <= rd_in;
        cnt  <= CNT_LOAD;
      end else if (complete) begin
        busy <= 1'b0;
      end else if (busy) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (start & ~accept)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: EX forwarding, load-use and MDU
// scoreboard stalls, and branch flushes.
module riscv_hazard_scoreboard import riscv_pkg::*; #(
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MDU_LAT = 4
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic [REG_AW-1:0] irs1_id,
  input  logic [REG_AW-1:0] irs2_id,
  input  logic              irs1_used_id,
  input  logic              irs2_used_id,
  input  logic [REG_AW-1:0] ird_id,
  input  logic              ireg_wr_id,
  input  logic              imdu_op_id,
  input  logic [REG_AW-1:0] irs1_ex,
  input  logic [REG_AW-1:0] irs2_ex,
  input  logic [REG_AW-1:0] ird_ex,
  input  logic              iresult_src_ex_b0,
  input  logic              ipc_src_ex,
  input  logic              imdu_start_ex,
  input  logic [REG_AW-1:0] ird_mem,
  input  logic [REG_AW-1:0] ird_wb,
  input  logic              ireg_wr_mem,
  input  logic              ireg_wr_wb,
  output logic [1:0]        oforward_ae,
  output logic [1:0]        oforward_be,
  output logic              ostall_if,
  output logic              ostall_id,
  output logic              oflush_id,
  output logic              oflush_ex,
  output logic              omdu_busy,
  output logic [REG_AW-1:0] omdu_rd,
  output logic              omdu_wb,
  output logic              osb_err
);

  logic lw_stall;
  logic sb_raw, sb_waw, sb_stall;
  logic stall;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
    if (rs != '0 && rs == ird_mem && ireg_wr_mem)     return FWD_MEM;
    else if (rs != '0 && rs == ird_wb && ireg_wr_wb)  return FWD_WB;
    else                                              return FWD_RF;
  endfunction

  assign oforward_ae = fwd_sel(irs1_ex);
  assign oforward_be = fwd_sel(irs2_ex);

  riscv_mdu_scoreboard #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT)
  ) u_sb (
    .clk   (iclk),
    .rst   (irst),
    .start (imdu_start_ex),
    .rd_in (ird_ex),
    .busy  (omdu_busy),
    .rd    (omdu_rd),
    .wb    (omdu_wb),
    .err   (osb_err)
  );

  assign lw_stall = iresult_src_ex_b0 & (ird_ex != '0) &
                    ((irs1_used_id & (irs1_id == ird_ex)) |
                     (irs2_used_id & (irs2_id == ird_ex)));

  // An x0 destination keeps the slot for structural purposes but never aliases.
  assign sb_raw   = (omdu_rd != '0) &
                    ((irs1_used_id & (irs1_id == omdu_rd)) |
                     (irs2_used_id & (irs2_id == omdu_rd)));
  assign sb_waw   = (omdu_rd != '0) & ireg_wr_id & (ird_id == omdu_rd);
  assign sb_stall = omdu_busy & (sb_raw | sb_waw | imdu_op_id);

  assign stall     = (lw_stall | sb_stall) & ~ipc_src_ex;
  assign ostall_if = stall;
  assign ostall_id = stall;
  assign oflush_id = ipc_src_ex;
  assign oflush_ex = stall | ipc_src_ex;

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard: each stimulus cycle queues its
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_riscv_hazard_scoreboard;

  logic       iclk = 1'b0;
  logic       irst;
  logic [4:0] irs1_id, irs2_id, ird_id;
  logic       irs1_used_id, irs2_used_id, ireg_wr_id, imdu_op_id;
  logic [4:0] irs1_ex, irs2_ex, ird_ex;
  logic       iresult_src_ex_b0, ipc_src_ex, imdu_start_ex;
  logic [4:0] ird_mem, ird_wb;
  logic       ireg_wr_mem, ireg_wr_wb;
  logic [1:0] oforward_ae, oforward_be;
  logic       ostall_if, ostall_id, oflush_id, oflush_ex;
  logic       omdu_busy, omdu_wb, osb_err;
  logic [4:0] omdu_rd;

  riscv_hazard_scoreboard #(.REG_AW(5), .MDU_LAT(4)) dut (
    .iclk(iclk), .irst(irst),
    .irs1_id(irs1_id), .irs2_id(irs2_id),
    .irs1_used_id(irs1_used_id), .irs2_used_id(irs2_used_id),
    .ird_id(ird_id), .ireg_wr_id(ireg_wr_id), .imdu_op_id(imdu_op_id),
    .irs1_ex(irs1_ex), .irs2_ex(irs2_ex), .ird_ex(ird_ex),
    .iresult_src_ex_b0(iresult_src_ex_b0), .ipc_src_ex(ipc_src_ex),
    .imdu_start_ex(imdu_start_ex),
    .ird_mem(ird_mem), .ird_wb(ird_wb),
    .ireg_wr_mem(ireg_wr_mem), .ireg_wr_wb(ireg_wr_wb),
    .oforward_ae(oforward_ae), .oforward_be(oforward_be),
    .ostall_if(ostall_if), .ostall_id(ostall_id),
    .oflush_id(oflush_id), .oflush_ex(oflush_ex),
    .omdu_busy(omdu_busy), .omdu_rd(omdu_rd),
    .omdu_wb(omdu_wb), .osb_err(osb_err)
  );

  always #5 iclk = ~iclk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // {fwd_a, fwd_b, stall_if, stall_id, flush_id, flush_ex, busy, rd, wb, err}
  function automatic logic [15:0] e(input logic [1:0] fa, input logic [1:0] fb,
                                    input logic st, input logic fid, input logic fex,
                                    input logic busy, input logic [4:0] rd,
                                    input logic wb, input logic err);
    return {fa, fb, st, st, fid, fex, busy, rd, wb, err};
  endfunction

  always @(negedge iclk) begin
    if (q.size() > 0) begin
      exp_t        x;
      logic [15:0] got;
      x   = q.pop_front();
      got = {oforward_ae, oforward_be, ostall_if, ostall_id, oflush_id, oflush_ex,
             omdu_busy, omdu_rd, omdu_wb, osb_err};
      n_tests++;
      if (got !== x.exp) begin
        n_fail++;
        $display("FAIL %s: got %04h expected %04h", x.name, got, x.exp);
      end
    end
  end

  task automatic idle();
    irs1_id = 0; irs2_id = 0; ird_id = 0;
    irs1_used_id = 0; irs2_used_id = 0; ireg_wr_id = 0; imdu_op_id = 0;
    irs1_ex = 0; irs2_ex = 0; ird_ex = 0;
    iresult_src_ex_b0 = 0; ipc_src_ex = 0; imdu_start_ex = 0;
    ird_mem = 0; ird_wb = 0; ireg_wr_mem = 0; ireg_wr_wb = 0;
  endtask

  task automatic step(input string name, input logic [15:0] exp);
    exp_t x;
    x.name = name;
    x.exp  = exp;
    q.push_back(x);
    @(posedge iclk);
    #1;
    idle();
  endtask

  initial begin
    irst = 1'b1;
    idle();
    @(posedge iclk); #1;
    step("reset", e(0,0,0,0,0, 0,0,0,0));
    irst = 1'b0;

    irs1_ex = 5; irs2_ex = 5; ird_mem = 5; ireg_wr_mem = 1; ird_wb = 5; ireg_wr_wb = 1;
    step("fwd_mem_prio", e(2'b10,2'b10,0,0,0, 0,0,0,0));
    irs1_ex = 5; irs2_ex = 3; ird_mem = 5; ireg_wr_mem = 0; ird_wb = 5; ireg_wr_wb = 1;
    step("fwd_wb", e(2'b01,2'b00,0,0,0, 0,0,0,0));
    irs1_ex = 0; ird_mem = 0; ireg_wr_mem = 1; ird_wb = 0; ireg_wr_wb = 1;
    step("fwd_x0", e(0,0,0,0,0, 0,0,0,0));

    iresult_src_ex_b0 = 1; ird_ex = 7; irs2_id = 7; irs2_used_id = 1;
    step("lw_stall", e(0,0,1,0,1, 0,0,0,0));
    iresult_src_ex_b0 = 1; ird_ex = 7; irs2_id = 7; irs2_used_id = 0;
    step("lw_unused", e(0,0,0,0,0, 0,0,0,0));
    iresult_src_ex_b0 = 1; ird_ex = 0; irs1_id = 0; irs1_used_id = 1;
    step("lw_x0", e(0,0,0,0,0, 0,0,0,0));

    imdu_start_ex = 1; ird_ex = 9;
    step("mdu_issue9", e(0,0,0,0,0, 0,0,0,0));
    irs1_id = 9; irs1_used_id = 1;
    step("raw_c1", e(0,0,1,0,1, 1,9,0,0));
    ird_id = 9; ireg_wr_id = 1; irs1_id = 9;
    step("waw_c2", e(0,0,1,0,1, 1,9,0,0));
    imdu_op_id = 1;
    step("struct_c3", e(0,0,1,0,1, 1,9,0,0));
    irs1_id = 9; irs1_used_id = 1;
    step("raw_complete", e(0,0,1,0,1, 1,9,1,0));
    irs1_id = 9; irs1_used_id = 1;
    step("raw_release", e(0,0,0,0,0, 0,9,0,0));

    imdu_start_ex = 1; ird_ex = 12;
    step("mdu_issue12", e(0,0,0,0,0, 0,9,0,0));
    irs1_id = 1; irs2_id = 2; irs1_used_id = 1; irs2_used_id = 1; ird_id = 3; ireg_wr_id = 1;
    step("unrelated_add", e(0,0,0,0,0, 1,12,0,0));
    irs1_id = 12; irs1_used_id = 1; ipc_src_ex = 1;
    step("branch_kill", e(0,0,0,1,1, 1,12,0,0));
    imdu_start_ex = 1; ird_ex = 20;
    step("issue_midbusy", e(0,0,0,0,0, 1,12,0,0));
    imdu_start_ex = 1; ird_ex = 21;
    step("b2b_complete", e(0,0,0,0,0, 1,12,1,1));
    step("b2b_new_entry", e(0,0,0,0,0, 1,21,0,1));
    irst = 1'b1;
    step("reset_mid_busy", e(0,0,0,0,0, 1,21,0,1));
    irst = 1'b0;
    step("after_reset", e(0,0,0,0,0, 0,0,0,0));
    step("no_wb_after_rst", e(0,0,0,0,0, 0,0,0,0));

    imdu_start_ex = 1; ird_ex = 0;
    step("mdu_issue_x0", e(0,0,0,0,0, 0,0,0,0));
    irs1_id = 0; irs1_used_id = 1; ird_id = 0; ireg_wr_id = 1;
    step("x0_no_alias", e(0,0,0,0,0, 1,0,0,0));
    imdu_op_id = 1;
    step("x0_struct", e(0,0,1,0,1, 1,0,0,0));
    step("x0_c3", e(0,0,0,0,0, 1,0,0,0));
    step("x0_complete", e(0,0,0,0,0, 1,0,1,0));
    step("x0_done", e(0,0,0,0,0, 0,0,0,0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge iclk);
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
